// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - serialises dual writeback destinations onto one register-file write port
module wb_port_arbiter #(
    parameter int          DATA_W = 64,
    parameter int          NREG   = 15,
    parameter logic [3:0]  RNONE  = 4'hF,
    parameter int          CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              W_valid,
    input  logic [3:0]        W_dstE,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valM,
    output logic              W_stall,
    output logic              rf_we,
    output logic [3:0]        rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic [CNT_W-1:0]  dual_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    // NREG widened to 5 bits so a 4-bit index compares cleanly even when NREG == 16
    localparam logic [4:0] NREG_L = 5'(NREG);

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          pend_addr;
    logic [DATA_W-1:0]   pend_data;
    logic                pend_load;
    logic                we_d;
    logic [3:0]          addr_d;
    logic [DATA_W-1:0]   data_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                live_e;
    logic                live_m;
    logic                accept;

    assign live_e  = (W_dstE != RNONE) && ({1'b0, W_dstE} < NREG_L);
    assign live_m  = (W_dstM != RNONE) && ({1'b0, W_dstM} < NREG_L);
    assign W_stall = (state_q == SECOND);
    assign accept  = W_valid && !W_stall;

    // Next-state and next-output selection; E goes first so M is the final value on a dual write
    always_comb begin
        state_d   = state_q;
        we_d      = 1'b0;
        addr_d    = rf_addr;
        data_d    = rf_data;
        pend_load = 1'b0;
        cnt_d     = dual_cnt;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (live_e && live_m && (W_dstE != W_dstM)) begin
                        we_d      = 1'b1;
                        addr_d    = W_dstE;
                        data_d    = W_valE;
                        pend_load = 1'b1;
                        state_d   = SECOND;
                        if (dual_cnt != {CNT_W{1'b1}}) begin
                            cnt_d = dual_cnt + 1'b1;
                        end
                    end else if (live_m) begin
                        we_d   = 1'b1;
                        addr_d = W_dstM;
                        data_d = W_valM;
                    end else if (live_e) begin
                        we_d   = 1'b1;
                        addr_d = W_dstE;
                        data_d = W_valE;
                    end
                end
            end
            SECOND: begin
                we_d    = 1'b1;
                addr_d  = pend_addr;
                data_d  = pend_data;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, registered write port, pending M latch and event counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rf_we     <= 1'b0;
            rf_addr   <= RNONE;
            rf_data   <= '0;
            dual_cnt  <= '0;
            pend_addr <= RNONE;
            pend_data <= '0;
        end else begin
            state_q  <= state_d;
            rf_we    <= we_d;
            rf_addr  <= addr_d;
            rf_data  <= data_d;
            dual_cnt <= cnt_d;
            if (pend_load) begin
                pend_addr <= W_dstM;
                pend_data <= W_valM;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    localparam int DW = 64;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          W_valid = 1'b0;
    logic [3:0]    W_dstE = 4'hF;
    logic [DW-1:0] W_valE = '0;
    logic [3:0]    W_dstM = 4'hF;
    logic [DW-1:0] W_valM = '0;
    logic          W_stall;
    logic          rf_we;
    logic [3:0]    rf_addr;
    logic [DW-1:0] rf_data;
    logic [CW-1:0] dual_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int seen_r2 = 0;

    wb_port_arbiter #(.DATA_W(DW), .NREG(15), .RNONE(4'hF), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .W_valid(W_valid),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .W_stall(W_stall), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .dual_cnt(dual_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted instruction becomes a list of writes that drain one per cycle;
    // the W stage is held while any of that list remains.
    typedef struct {
        logic [3:0]    a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           wq[$];
    logic          m_we = 1'b0;
    logic [3:0]    m_addr = 4'hF;
    logic [DW-1:0] m_data = '0;
    logic [CW-1:0] m_cnt = '0;

    function automatic bit is_live(input logic [3:0] r);
        return (r != 4'hF) && (int'(r) < 15);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq.delete();
            m_we   = 1'b0;
            m_addr = 4'hF;
            m_data = '0;
            m_cnt  = '0;
        end else begin
            if (wq.size() == 0 && W_valid) begin
                if (is_live(W_dstE) && is_live(W_dstM) && W_dstE != W_dstM) begin
                    wq.push_back('{W_dstE, W_valE});
                    wq.push_back('{W_dstM, W_valM});
                    if (m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
                end else if (is_live(W_dstM)) begin
                    wq.push_back('{W_dstM, W_valM});
                end else if (is_live(W_dstE)) begin
                    wq.push_back('{W_dstE, W_valE});
                end
            end
            if (wq.size() > 0) begin
                wr_t w;
                w = wq.pop_front();
                m_we   = 1'b1;
                m_addr = w.a;
                m_data = w.d;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("rf_we", {63'b0, rf_we}, {63'b0, m_we});
        chk("rf_addr", {60'b0, rf_addr}, {60'b0, m_addr});
        chk("rf_data", rf_data, m_data);
        chk("W_stall", {63'b0, W_stall}, {63'b0, (wq.size() > 0)});
        chk("dual_cnt", {60'b0, dual_cnt}, {60'b0, m_cnt});
        if (rf_we === 1'b1 && rf_addr === 4'd2) seen_r2++;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [3:0] de, input logic [DW-1:0] ve,
                           input logic [3:0] dm, input logic [DW-1:0] vm);
        W_valid = v;
        W_dstE  = de;
        W_valE  = ve;
        W_dstM  = dm;
        W_valM  = vm;
    endtask

    initial begin
        // reset then idle
        repeat (3) tick();
        chk("rst_we", {63'b0, rf_we}, 64'd0);
        chk("rst_addr", {60'b0, rf_addr}, 64'hF);
        chk("rst_cnt", {60'b0, dual_cnt}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_we", {63'b0, rf_we}, 64'd0);
            chk("idle_stall", {63'b0, W_stall}, 64'd0);
            chk("idle_addr", {60'b0, rf_addr}, 64'hF);
        end

        // single E write
        set_req(1, 4'd3, 64'h1234, 4'hF, 64'h0);
        tick();
        chk("e_we", {63'b0, rf_we}, 64'd1);
        chk("e_addr", {60'b0, rf_addr}, 64'd3);
        chk("e_data", rf_data, 64'h1234);
        chk("e_stall", {63'b0, W_stall}, 64'd0);
        chk("e_cnt", {60'b0, dual_cnt}, 64'd0);

        // single M write
        set_req(1, 4'hF, 64'h55, 4'd7, 64'h77);
        tick();
        chk("m_addr", {60'b0, rf_addr}, 64'd7);
        chk("m_data", rf_data, 64'h77);
        set_req(0, 4'hF, 64'h0, 4'hF, 64'h0);
        tick();
        chk("m_idle_we", {63'b0, rf_we}, 64'd0);

        // dual distinct write with a follow-on request held across the stall
        set_req(1, 4'd4, 64'hA, 4'd5, 64'hB);
        tick();
        chk("d1_addr", {60'b0, rf_addr}, 64'd4);
        chk("d1_data", rf_data, 64'hA);
        chk("d1_stall", {63'b0, W_stall}, 64'd1);
        set_req(1, 4'd6, 64'hC, 4'hF, 64'h0);
        tick();
        chk("d2_addr", {60'b0, rf_addr}, 64'd5);
        chk("d2_data", rf_data, 64'hB);
        chk("d2_stall", {63'b0, W_stall}, 64'd0);
        chk("d2_cnt", {60'b0, dual_cnt}, 64'd1);
        tick();
        chk("d3_addr", {60'b0, rf_addr}, 64'd6);
        chk("d3_data", rf_data, 64'hC);
        set_req(0, 4'hF, 64'h0, 4'hF, 64'h0);
        tick();

        // same-register conflict: M wins, no stall
        set_req(1, 4'd4, 64'h1, 4'd4, 64'h2);
        tick();
        chk("c_addr", {60'b0, rf_addr}, 64'd4);
        chk("c_data", rf_data, 64'h2);
        chk("c_stall", {63'b0, W_stall}, 64'd0);
        chk("c_cnt", {60'b0, dual_cnt}, 64'd1);
        set_req(0, 4'hF, 64'h0, 4'hF, 64'h0);
        tick();
        chk("c_we_after", {63'b0, rf_we}, 64'd0);

        // reset during SECOND discards the pending M write
        seen_r2 = 0;
        set_req(1, 4'd1, 64'h11, 4'd2, 64'h22);
        tick();
        chk("r_addr", {60'b0, rf_addr}, 64'd1);
        chk("r_stall", {63'b0, W_stall}, 64'd1);
        set_req(0, 4'hF, 64'h0, 4'hF, 64'h0);
        rst_n = 1'b0;
        #1;
        chk("r_async_we", {63'b0, rf_we}, 64'd0);
        chk("r_async_stall", {63'b0, W_stall}, 64'd0);
        chk("r_async_cnt", {60'b0, dual_cnt}, 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("r_no_reg2", 64'(seen_r2), 64'd0);

        // counter saturation across 17 dual writes, E before M each time
        for (int i = 0; i < 17; i++) begin
            logic [3:0] e;
            e = 4'(i % 14);
            set_req(1, e, 64'(100 + i), e + 4'd1, 64'(200 + i));
            tick();
            chk("s_e_addr", {60'b0, rf_addr}, {60'b0, e});
            chk("s_e_data", rf_data, 64'(100 + i));
            tick();
            chk("s_m_addr", {60'b0, rf_addr}, {60'b0, e + 4'd1});
            chk("s_m_data", rf_data, 64'(200 + i));
        end
        set_req(0, 4'hF, 64'h0, 4'hF, 64'h0);
        tick();
        chk("s_cnt_sat", {60'b0, dual_cnt}, 64'hF);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Sequences register-file writes from the writeback stage through a single physical register-file write port.
- A writeback instruction can carry two destinations (dstE/valE and dstM/valM). When both are live and distinct, this block issues them over two cycles and stalls the W stage for one cycle.
- It sits between the W pipeline register and the 15-entry register file. It also keeps a saturating count of dual-write events for performance monitoring.

Parameters:
- DATA_W, 64, register data width
- NREG, 15, number of architectural registers (indices 0..NREG-1)
- RNONE, 4'hF, destination code meaning "no write"
- CNT_W, 16, width of the dual-write event counter

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- W_valid  input  1  W stage holds a valid instruction requesting writeback
- W_dstE  input  4  E-port destination register; RNONE = none
- W_valE  input  DATA_W  E-port write data
- W_dstM  input  4  M-port destination register; RNONE = none
- W_valM  input  DATA_W  M-port write data
- W_stall  output  1  hold W pipeline register; the request is not accepted while high
- rf_we  output  1  register-file write enable (registered)
- rf_addr  output  4  register-file write address (registered)
- rf_data  output  DATA_W  register-file write data (registered)
- dual_cnt  output  CNT_W  saturating count of accepted dual-write requests

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; rf_we=0; rf_addr=RNONE; rf_data=0; dual_cnt=0; pending M latch cleared; W_stall=0.
- Destination validity: a destination is live iff it is not RNONE and is less than NREG. Any non-live code, including RNONE, is treated as no write.
- W_stall = (state==SECOND). It is combinational from state only and never depends on the inputs.
- Acceptance: a request is accepted at a posedge when W_valid=1 and W_stall=0. Inputs are ignored while W_stall=1; upstream holds them stable.
- Latency: the first write appears on rf_* exactly 1 cycle after acceptance (outputs registered at the accepting edge). The register file samples rf_* on the following edge.
- FSM states: IDLE, SECOND.
- IDLE, accepted, neither destination live: rf_we<=0; stay IDLE.
- IDLE, accepted, only E live: rf_we<=1, rf_addr<=dstE, rf_data<=valE; stay IDLE.
- IDLE, accepted, only M live: rf_we<=1, rf_addr<=dstM, rf_data<=valM; stay IDLE.
- IDLE, accepted, both live and dstE==dstM: M wins and only M is written (single cycle, no stall). dual_cnt is unchanged.
- IDLE, accepted, both live and distinct: issue E first (rf_we<=1, rf_addr<=dstE, rf_data<=valE); latch dstM/valM into the pending register; go to SECOND; dual_cnt<=dual_cnt+1, saturating at all-ones.
- SECOND: rf_we<=1, rf_addr<=pending dstM, rf_data<=pending valM; go to IDLE. W_stall is high during this cycle, so no new request is accepted at this edge.
- IDLE, no acceptance (W_valid=0): rf_we<=0. rf_addr and rf_data hold their previous values (don't-care when rf_we=0).
- Ordering guarantee: for any instruction, the E write always precedes the M write, so M is the final value of any register written by both.
- Back-to-back: in IDLE, a new request may be accepted every cycle. After SECOND, a new request can be accepted on the first IDLE edge, giving zero bubble beyond the one stall cycle.
- Reset during SECOND: the pending M write is discarded. State, outputs and counter return to reset values immediately.
- dual_cnt saturation: at 2^CNT_W-1 further dual events leave it unchanged. No wrap-around.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, then release with W_valid=0 for 5 cycles -> rf_we=0, W_stall=0, dual_cnt=0, rf_addr=4'hF throughout.
- Single E write: W_valid=1, dstE=3, valE=64'h1234, dstM=F -> cycle after acceptance shows rf_we=1, rf_addr=3, rf_data=64'h1234; W_stall stays 0; dual_cnt=0.
- Dual distinct write: dstE=4, valE=64'hA, dstM=5, valM=64'hB -> cycle+1: rf_we=1, addr 4, data A, W_stall=1; cycle+2: addr 5, data B, W_stall=0; dual_cnt=1. A new request (dstE=6, valE=64'hC) held during the stall is accepted on the next edge and written at cycle+3.
- Same-register conflict: dstE=dstM=4, valE=64'h1, valM=64'h2 -> exactly one write, addr 4, data 64'h2; W_stall never asserts; dual_cnt unchanged.
- Reset mid-sequence: dual write dstE=1, dstM=2, then assert rst_n=0 while in SECOND -> rf_we drops to 0 asynchronously; no write to register 2 is ever issued; dual_cnt=0.
- Counter saturation (CNT_W=4): issue 17 dual distinct writes -> dual_cnt reaches 4'hF and holds; every write pair is still issued in E-then-M order.
